// File: rtl/laser_scan_sched.sv
// Scan sequencer for the circle-coverage scoring engine: alternating C1/C2 full-grid passes,
// best-centre tracking, per-pass shade commit and a convergence check per iteration.
module laser_scan_sched #(
   parameter int unsigned GRID_W   = 4,
   parameter int unsigned SCORE_W  = 6,
   parameter int unsigned MAX_ITER = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               eng_req,
   output logic [GRID_W-1:0]  eng_cx,
   output logic [GRID_W-1:0]  eng_cy,
   output logic               eng_pass,
   input  logic               eng_ack,
   input  logic [SCORE_W-1:0] eng_score,
   output logic               eng_commit,
   output logic [GRID_W-1:0]  C1X,
   output logic [GRID_W-1:0]  C1Y,
   output logic [GRID_W-1:0]  C2X,
   output logic [GRID_W-1:0]  C2Y,
   output logic [3:0]         iter_cnt
);

   typedef enum logic [2:0] {IDLE, SCAN1, COMMIT1, SCAN2, COMMIT2, CHECK, FIN} state_t;

   localparam logic [3:0]          ITER_CAP = 4'(MAX_ITER);
   localparam logic [2*GRID_W-1:0] POS_ONE  = {{(2*GRID_W-1){1'b0}}, 1'b1};

   state_t              state;
   logic [SCORE_W-1:0]  best_score;
   logic [GRID_W-1:0]   b1x, b1y, b2x, b2y;
   logic [GRID_W-1:0]   p1x, p1y, p2x, p2y;
   logic                in_scan, take, better, last_cand, converged;
   logic [GRID_W-1:0]   win_x, win_y;
   logic [2*GRID_W-1:0] pos_next;
   logic [3:0]          iter_next;

   // win_x/win_y fold the final candidate's score in, so the commit sees the true pass winner
   always_comb begin
      in_scan   = (state == SCAN1) || (state == SCAN2);
      take      = in_scan && eng_ack;
      better    = take && (eng_score > best_score);
      last_cand = (eng_cx == '1) && (eng_cy == '1);
      pos_next  = {eng_cy, eng_cx} + POS_ONE;
      win_x     = better ? eng_cx : ((state == SCAN1) ? b1x : b2x);
      win_y     = better ? eng_cy : ((state == SCAN1) ? b1y : b2y);
      iter_next = (iter_cnt < ITER_CAP) ? iter_cnt + 4'd1 : iter_cnt;
      converged = ({b1x, b1y, b2x, b2y} == {p1x, p1y, p2x, p2y});
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         eng_req    <= 1'b0;
         eng_cx     <= '0;
         eng_cy     <= '0;
         eng_pass   <= 1'b0;
         eng_commit <= 1'b0;
         C1X        <= '0;
         C1Y        <= '0;
         C2X        <= '0;
         C2Y        <= '0;
         iter_cnt   <= '0;
         best_score <= '0;
         {b1x, b1y, b2x, b2y} <= '0;
         {p1x, p1y, p2x, p2y} <= '0;
      end else begin
         done       <= 1'b0;
         eng_commit <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SCAN1;
                  busy       <= 1'b1;
                  iter_cnt   <= '0;
                  {p1x, p1y, p2x, p2y} <= '0;
                  eng_req    <= 1'b1;
                  eng_cx     <= '0;
                  eng_cy     <= '0;
                  eng_pass   <= 1'b0;
                  best_score <= '0;
                  {b1x, b1y} <= '0;
               end
            end
            SCAN1, SCAN2: begin
               if (take) begin
                  if (better) begin
                     best_score <= eng_score;
                     if (state == SCAN1) {b1x, b1y} <= {eng_cx, eng_cy};
                     else                {b2x, b2y} <= {eng_cx, eng_cy};
                  end
                  if (last_cand) begin
                     state      <= (state == SCAN1) ? COMMIT1 : COMMIT2;
                     eng_req    <= 1'b0;
                     eng_commit <= 1'b1;
                     eng_cx     <= win_x;
                     eng_cy     <= win_y;
                  end else begin
                     {eng_cy, eng_cx} <= pos_next;
                  end
               end
            end
            COMMIT1: begin
               state      <= SCAN2;
               eng_req    <= 1'b1;
               eng_cx     <= '0;
               eng_cy     <= '0;
               eng_pass   <= 1'b1;
               best_score <= '0;
               {b2x, b2y} <= '0;
            end
            COMMIT2: state <= CHECK;
            CHECK: begin
               iter_cnt <= iter_next;
               if (converged || (iter_next >= ITER_CAP)) begin
                  state <= FIN;
                  done  <= 1'b1;
                  C1X   <= b1x;
                  C1Y   <= b1y;
                  C2X   <= b2x;
                  C2Y   <= b2y;
               end else begin
                  state      <= SCAN1;
                  {p1x, p1y, p2x, p2y} <= {b1x, b1y, b2x, b2y};
                  eng_req    <= 1'b1;
                  eng_cx     <= '0;
                  eng_cy     <= '0;
                  eng_pass   <= 1'b0;
                  best_score <= '0;
                  {b1x, b1y} <= '0;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_laser_scan_sched.sv
// Bench for laser_scan_sched: behavioural engine with selectable score maps and ack styles,
// a scan-order/stability monitor, and an argmax/convergence reference model.
module tb_laser_scan_sched;

   logic       CLK = 1'b0, RST = 1'b1, start = 1'b0;
   logic       busy, done, eng_req, eng_pass, eng_commit;
   logic [3:0] eng_cx, eng_cy, C1X, C1Y, C2X, C2Y, iter_cnt;
   logic       eng_ack = 1'b0;
   logic [5:0] eng_score = '0;

   int tests = 0, fails = 0;
   int pat = 0, ackm = 0;
   int tab [2][256];

   int         cur_len = 0, exp_idx = 0, done_cnt = 0, commit_cnt = 0;
   int         order_err = 0, stab_err = 0, acks = 0;
   logic [8:0] commit_q[$];
   int         plen_q[$];
   logic       prev_req = 1'b0, prev_ack = 1'b0;
   logic [8:0] prev_cand = '0;

   typedef struct {
      int         pat;
      int         ackm;
      logic [15:0] cent;   // {c1x, c1y, c2x, c2y}
      int         iters;
      int         plen;
      bit         glitch;
   } vec_t;
   vec_t vecs[5];

   laser_scan_sched #(.GRID_W(4), .SCORE_W(6), .MAX_ITER(8)) dut (
      .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
      .eng_req(eng_req), .eng_cx(eng_cx), .eng_cy(eng_cy), .eng_pass(eng_pass),
      .eng_ack(eng_ack), .eng_score(eng_score), .eng_commit(eng_commit),
      .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .iter_cnt(iter_cnt)
   );

   always #5 CLK = ~CLK;

   function automatic int score_of(input int p_pat, input int pass, input int it, input int idx);
      int x, y;
      x = idx % 16;
      y = idx / 16;
      case (p_pat)
         0: return ((pass == 0 && x == 5 && y == 7) || (pass == 1 && x == 9 && y == 2)) ? 1 : 0;
         1: return (y == 3 && (x == 3 || x == 12)) ? 10 : 0;
         2: return (y == 0 && x == (it + 1) % 16) ? 1 : 0;
         4: return tab[pass][idx];
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: strict argmax in scan order per pass, repeated until both winners repeat or cap
   task automatic model(input int p_pat, output logic [15:0] cent, output int iters);
      int prev1, prev2, best, s;
      int b[2];
      prev1 = 0; prev2 = 0; iters = 0; b[0] = 0; b[1] = 0;
      for (int it = 0; it < 8; it++) begin
         for (int p = 0; p < 2; p++) begin
            best = 0; b[p] = 0;
            for (int i = 0; i < 256; i++) begin
               s = score_of(p_pat, p, it, i);
               if (s > best) begin best = s; b[p] = i; end
            end
         end
         iters = it + 1;
         if ((b[0] == prev1 && b[1] == prev2) || iters == 8) break;
         prev1 = b[0]; prev2 = b[1];
      end
      cent = {4'(b[0] % 16), 4'(b[0] / 16), 4'(b[1] % 16), 4'(b[1] / 16)};
   endtask

   // Engine + monitor: drives ack/score for the candidate on the bus, logs commits and order
   always @(negedge CLK) begin : engine
      logic ack;
      int   s;
      if (RST) begin cur_len = 0; exp_idx = 0; end
      else if (start && !busy) begin
         cur_len = 0; exp_idx = 0; done_cnt = 0; commit_cnt = 0;
         order_err = 0; stab_err = 0; acks = 0;
         commit_q.delete(); plen_q.delete();
      end
      if (eng_commit) begin
         commit_q.push_back({eng_pass, eng_cy, eng_cx});
         plen_q.push_back(cur_len);
         commit_cnt++;
         cur_len = 0; exp_idx = 0;
      end
      if (done) done_cnt++;
      if (eng_req && prev_req && !prev_ack && ({eng_pass, eng_cy, eng_cx} !== prev_cand)) stab_err++;
      case (ackm)
         0: ack = 1'b1;
         1: ack = eng_req && (cur_len % 3 == 2);
         default: ack = ($urandom_range(0, 1) == 1);
      endcase
      s = score_of(pat, int'(eng_pass), commit_cnt / 2, int'({eng_cy, eng_cx}));
      if (eng_req) begin
         if (ack) begin
            if ({eng_cy, eng_cx} !== 8'(exp_idx)) order_err++;
            exp_idx = (exp_idx + 1) % 256;
            acks++;
         end
         cur_len++;
      end
      prev_req  = eng_req;
      prev_ack  = ack;
      prev_cand = {eng_pass, eng_cy, eng_cx};
      eng_ack   = ack;
      eng_score = 6'(s);
   end

   task automatic run_solve(input string tag, input int p, input int am, input logic [15:0] exp_c,
                            input int exp_it, input int plen, input bit glitch);
      bit seen;
      int bad;
      seen = 0; bad = 0;
      pat = p; ackm = am;
      @(posedge CLK); #2 start = 1'b1;
      @(posedge CLK); #1;
      check({tag, "/busy_after_start"}, int'(busy), 1);
      check({tag, "/iter_cnt_fresh"}, int'(iter_cnt), 0);
      #1 start = 1'b0;
      for (int c = 0; c < 20000 && !seen; c++) begin
         @(posedge CLK); #1;
         start = (glitch && c == 40);
         if (done) begin
            seen = 1;
            check({tag, "/busy_at_done"}, int'(busy), 1);
            check({tag, "/centres"}, int'({C1X, C1Y, C2X, C2Y}), int'(exp_c));
            check({tag, "/iter_cnt"}, int'(iter_cnt), exp_it);
         end
      end
      start = 1'b0;
      if (!seen) check({tag, "/done_timeout"}, 0, 1);
      @(posedge CLK); #1;
      check({tag, "/busy_after_done"}, int'(busy), 0);
      check({tag, "/done_one_cycle"}, int'(done), 0);
      repeat (3) @(posedge CLK);
      #1;
      check({tag, "/done_count"}, done_cnt, 1);
      check({tag, "/commit_count"}, commit_cnt, 2 * exp_it);
      check({tag, "/centres_hold"}, int'({C1X, C1Y, C2X, C2Y}), int'(exp_c));
      if (commit_q.size() >= 2) begin
         check({tag, "/commit_c1"}, int'(commit_q[commit_q.size()-2]), int'({1'b0, exp_c[11:8], exp_c[15:12]}));
         check({tag, "/commit_c2"}, int'(commit_q[commit_q.size()-1]), int'({1'b1, exp_c[3:0], exp_c[7:4]}));
      end
      foreach (commit_q[i]) begin
         if (int'(commit_q[i][8]) != i % 2) bad++;
         if (plen != 0 && plen_q[i] != plen) bad++;
      end
      check({tag, "/pass_seq_len"}, bad, 0);
      check({tag, "/scan_order"}, order_err, 0);
      check({tag, "/hold_stable"}, stab_err, 0);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [15:0] mc;
      int          mi;

      vecs[0] = '{pat: 0, ackm: 0, cent: 16'h5792, iters: 2, plen: 256, glitch: 1'b0};
      vecs[1] = '{pat: 1, ackm: 0, cent: 16'h3333, iters: 2, plen: 256, glitch: 1'b0};
      vecs[2] = '{pat: 0, ackm: 1, cent: 16'h5792, iters: 2, plen: 768, glitch: 1'b1};
      vecs[3] = '{pat: 2, ackm: 0, cent: 16'h8080, iters: 8, plen: 256, glitch: 1'b0};
      vecs[4] = '{pat: 3, ackm: 0, cent: 16'h0000, iters: 1, plen: 256, glitch: 1'b0};

      repeat (3) @(posedge CLK);
      #1;
      check("reset/busy", int'(busy), 0);
      check("reset/done", int'(done), 0);
      check("reset/eng_req", int'(eng_req), 0);
      check("reset/eng_commit", int'(eng_commit), 0);
      check("reset/eng_bus", int'({eng_pass, eng_cx, eng_cy}), 0);
      check("reset/centres", int'({C1X, C1Y, C2X, C2Y}), 0);
      check("reset/iter_cnt", int'(iter_cnt), 0);
      #1 RST = 1'b0;

      // Abort in the middle of SCAN1 at candidate 100
      pat = 0; ackm = 0;
      @(posedge CLK); #2 start = 1'b1;
      @(posedge CLK); #2 start = 1'b0;
      for (int c = 0; c < 2000 && acks < 100; c++) begin
         @(posedge CLK); #1;
      end
      check("abort/candidate", int'({eng_cy, eng_cx}), 100);
      check("abort/pass", int'(eng_pass), 0);
      RST = 1'b1;
      @(posedge CLK); #1;
      check("abort/idle_outputs", int'({busy, eng_req, eng_commit, done}), 0);
      repeat (3) @(posedge CLK);
      #1;
      check("abort/no_done", done_cnt, 0);
      check("abort/no_commit", commit_cnt, 0);
      RST = 1'b0;

      for (int i = 0; i < 5; i++)
         run_solve($sformatf("vec%0d", i), vecs[i].pat, vecs[i].ackm, vecs[i].cent,
                   vecs[i].iters, vecs[i].plen, vecs[i].glitch);

      for (int t = 0; t < 4; t++) begin
         for (int p = 0; p < 2; p++)
            for (int i = 0; i < 256; i++)
               tab[p][i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : 0;
         model(4, mc, mi);
         run_solve($sformatf("rand%0d", t), 4, 2, mc, mi, 0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
